ramrom_banker: RTL

RAMROM_BANKER -- requirements
Module: ramrom_banker

---
 rtl/ramrom_banker_pkg.sv | 36 +++
 rtl/ramrom_banker_if.sv | 27 ++
 rtl/ramrom_waitgen.sv | 61 ++++++
 rtl/ramrom_banker.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ramrom_banker_pkg.sv
// ramrom_banker shared constants: register offsets, CONTROL bits,
// wait-state FSM encoding and address region boundaries.
package ramrom_banker_pkg;

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_JUMPER  = 2'd1;
  localparam logic [1:0] REG_CONTROL = 2'd2;
  localparam logic [1:0] REG_BANK    = 2'd3;

  localparam int CTL_EXTRAM = 0;
  localparam int CTL_DSKRAM = 1;
  localparam int CTL_DSKROM = 2;
  localparam int CTL_BEEB   = 3;
  localparam int CTL_WP     = 4;
  localparam int CTL_WS_LO  = 5;
  localparam int CTL_WS_HI  = 6;

  typedef logic [0:0] ws_state_t;
  localparam ws_state_t ST_IDLE    = 1'b0;
  localparam ws_state_t ST_STRETCH = 1'b1;

  localparam logic [15:0] DSK_PG_LO = 16'h0A00;
  localparam logic [15:0] DSK_PG_HI = 16'h0AFF;
  localparam logic [15:0] BEEB_LO   = 16'h6000;
  localparam logic [15:0] RAM_TOP   = 16'h7FFF;
  localparam logic [15:0] BANK_LO   = 16'hA000;
  localparam logic [15:0] BANK_HI   = 16'hAFFF;
  localparam logic [15:0] BUF_LO    = 16'hBC00;
  localparam logic [15:0] BUF_HI    = 16'hBFF0;
  localparam logic [15:0] SYS_LO    = 16'hC000;
  localparam logic [15:0] SYS_HI    = 16'hDFFF;
  localparam logic [15:0] DROM_LO   = 16'hE000;
  localparam logic [15:0] DROM_HI   = 16'hEFFF;
  localparam logic [15:0] TOP_LO    = 16'hF000;

endpackage

// File: rtl/ramrom_banker_if.sv
// CPU-side bus bundle of the banker: address/control in,
// chip selects, strobes, upper address and RDY out.
interface ramrom_banker_if #(
  parameter int RA_W = 5
);
  logic [15:0]     Addr;
  logic            RW;
  logic            SpeedSW;
  logic            DskROMSW;
  logic [RA_W-1:0] RA;
  logic            NRDS;
  logic            NWDS;
  logic            NRAMCS;
  logic            NROMCS;
  logic            NBuffCtl;
  logic            RDY;

  modport master (
    output Addr, RW, SpeedSW, DskROMSW,
    input  RA, NRDS, NWDS, NRAMCS, NROMCS, NBuffCtl, RDY
  );

  modport slave (
    input  Addr, RW, SpeedSW, DskROMSW,
    output RA, NRDS, NWDS, NRAMCS, NROMCS, NBuffCtl, RDY
  );
endinterface

// File: rtl/ramrom_waitgen.sv
// ROM wait-state generator: stretches a ROM read to ws_i+1 cycles.
// Ports: clk_i (falling edge), rst_ni, cond_i, ws_i -> rdy_o, state_o, ws_cnt_o.
module ramrom_waitgen
  import ramrom_banker_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       cond_i,
  input  logic [1:0] ws_i,
  output logic       rdy_o,
  output ws_state_t  state_o,
  output logic [1:0] ws_cnt_o
);

  ws_state_t  state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cond_i) begin
          state_d = ST_STRETCH;
          cnt_d   = ws_i - 2'd1;
        end
      end
      ST_STRETCH: begin
        if (!cond_i) begin
          state_d = ST_IDLE;
          cnt_d   = 2'd0;
        end else if (cnt_q != 2'd0) begin
          cnt_d = cnt_q - 2'd1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Reset forces RDY high even while a ROM address is still presented.
  assign rdy_o = ~(rst_ni & cond_i &
                   ((state_q == ST_IDLE) | (cnt_q != 2'd0)));
  assign state_o  = state_q;
  assign ws_cnt_o = cnt_q;

endmodule

// File: rtl/ramrom_banker.sv
// Memory banker: RAM/ROM decode, bank and CONTROL registers, ROM wait states.
// Ports: PHI2, NRST, Data (inout), bus (Addr/RW/switches in; RA, strobes, selects, RDY out).
module ramrom_banker
  import ramrom_banker_pkg::*;
#(
  parameter int          NUM_BANKS    = 16,
  parameter int          BANK_BITS    = $clog2(NUM_BANKS),
  parameter int          RA_W         = BANK_BITS + 1,
  parameter logic [15:0] REG_BASE     = 16'hBFFC,
  parameter int          SWITCH_DELAY = 2
) (
  input  logic           PHI2,
  input  logic           NRST,
  inout  wire  [7:0]     Data,
  ramrom_banker_if.slave bus
);

  localparam int DLY_W =
    (SWITCH_DELAY < 2) ? 1 : $clog2(SWITCH_DELAY + 1);

  logic [7:0]           ctrl_q, ctrl_d;
  logic [BANK_BITS-1:0] abank_q, abank_d;
  logic [BANK_BITS-1:0] pbank_q, pbank_d;
  logic                 pend_q, pend_d;
  logic [DLY_W-1:0]     dly_q, dly_d;

  logic [15:0] a;
  logic in_reg, reg_wr, ctrl_wr, bank_wr;
  logic dsk_ram_en, dsk_rom_en, beeb;
  logic bank_win, dsk_pg, e_pg, beeb_rom;
  logic ram_bank, ram_sel, rom_bank, rom_sys, rom_sel;
  logic wp_block, stretch, rdy;
  logic [1:0] ws, ws_cnt;
  ws_state_t st;
  logic [RA_W-1:0] ra;
  logic [7:0] rd_data;

  assign a       = bus.Addr;
  assign in_reg  = (a[15:2] == REG_BASE[15:2]);
  assign reg_wr  = in_reg & ~bus.RW;
  assign ctrl_wr = reg_wr & (a[1:0] == REG_CONTROL);
  assign bank_wr = reg_wr & (a[1:0] == REG_BANK);

  assign dsk_ram_en = ctrl_q[CTL_DSKRAM] ^ ~bus.DskROMSW;
  assign dsk_rom_en = ctrl_q[CTL_DSKROM] ^ ~bus.DskROMSW;
  assign beeb       = ctrl_q[CTL_BEEB];
  assign ws         = ctrl_q[CTL_WS_HI:CTL_WS_LO];

  assign bank_win = (a >= BANK_LO) && (a <= BANK_HI);
  assign dsk_pg   = (a >= DSK_PG_LO) && (a <= DSK_PG_HI);
  assign e_pg     = (a >= DROM_LO) && (a <= DROM_HI);
  // BeebMode maps ROM over $6000-$7FFF and $E000-$FFFF.
  assign beeb_rom = beeb & (((a >= BEEB_LO) && (a <= RAM_TOP)) ||
                            (a >= DROM_LO));

  assign ram_bank = bank_win & ctrl_q[CTL_EXTRAM] &
                    (abank_q == '0) & ~beeb;
  assign ram_sel  = ~beeb_rom &
                    (((a <= RAM_TOP) && !dsk_pg) |
                     (dsk_pg & (dsk_ram_en | beeb)) |
                     ram_bank);
  assign rom_bank = bank_win & ~ram_bank;
  assign rom_sys  = ((a >= SYS_LO) && (a <= SYS_HI)) |
                    (a >= TOP_LO) |
                    (e_pg & dsk_rom_en) |
                    beeb_rom;
  assign rom_sel  = rom_bank | rom_sys;

  always_comb begin
    ra = '0;
    unique case (1'b1)
      ram_sel:  ra = a[15] ? RA_W'(3'b111) : RA_W'(a[14:12]);
      rom_bank: ra = {1'b0, abank_q};
      rom_sys:  ra = {1'b1, {(RA_W-4){1'b0}}, ~dsk_rom_en, a[13:12]};
      default:  ra = '0;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_wr) ctrl_d = Data & 8'h7F;
  end

  always_comb begin
    abank_d = abank_q;
    pbank_d = pbank_q;
    pend_d  = pend_q;
    dly_d   = dly_q;
    if (bank_wr) begin
      pbank_d = Data[BANK_BITS-1:0];
      if (SWITCH_DELAY == 0) begin
        abank_d = Data[BANK_BITS-1:0];
      end else begin
        pend_d = 1'b1;
        dly_d  = DLY_W'(SWITCH_DELAY);
      end
    end else if (pend_q) begin
      dly_d = dly_q - DLY_W'(1);
      if (dly_q == DLY_W'(1)) begin
        abank_d = pbank_q;
        pend_d  = 1'b0;
      end
    end
  end

  always_ff @(negedge PHI2 or negedge NRST) begin
    if (!NRST) begin
      ctrl_q  <= '0;
      abank_q <= '0;
      pbank_q <= '0;
      pend_q  <= 1'b0;
      dly_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      abank_q <= abank_d;
      pbank_q <= pbank_d;
      pend_q  <= pend_d;
      dly_q   <= dly_d;
    end
  end

  assign stretch = rom_sel & bus.RW & bus.SpeedSW & (ws != 2'd0);

  ramrom_waitgen u_wait (
    .clk_i    (PHI2),
    .rst_ni   (NRST),
    .cond_i   (stretch),
    .ws_i     (ws),
    .rdy_o    (rdy),
    .state_o  (st),
    .ws_cnt_o (ws_cnt)
  );

  always_comb begin
    rd_data = '0;
    unique case (a[1:0])
      REG_STATUS:  rd_data = {pend_q, st == ST_STRETCH, ws_cnt, 4'b0};
      REG_JUMPER:  rd_data = {bus.SpeedSW, ~bus.DskROMSW, 6'b0};
      REG_CONTROL: rd_data = ctrl_q;
      REG_BANK:    rd_data = {pend_q, {(7-BANK_BITS){1'b0}}, abank_q};
      default:     rd_data = '0;
    endcase
  end

  assign Data = (PHI2 & bus.RW & in_reg) ? rd_data : 8'bz;

  // Protected bank RAM: the write strobe is simply never issued.
  assign wp_block = ctrl_q[CTL_WP] & ram_bank & ~bus.RW;

  assign bus.RA       = ra;
  assign bus.NRDS     = ~(PHI2 & bus.RW);
  assign bus.NWDS     = ~(PHI2 & ~bus.RW & ~wp_block);
  assign bus.NRAMCS   = ~ram_sel;
  assign bus.NROMCS   = ~rom_sel;
  assign bus.NBuffCtl = ~(((a >= BUF_LO) && (a <= BUF_HI) && !in_reg) |
                          (dsk_pg & ~dsk_ram_en & ~beeb) |
                          (e_pg & ~dsk_rom_en));
  assign bus.RDY      = rdy;

endmodule
